// File: rtl/rx_line_buffer.sv
// Line-assembly buffer behind the UART receiver: collects bytes up to "\r\n" and streams the line out.
// Optional build macro LINE_BUF_STRIP_EN removes the CR,LF terminator from the delivered line.
module rx_line_buffer #(
    parameter int          DEPTH    = 64,
    parameter int          AW       = 6,
    parameter logic [7:0]  CARRIAGE = 8'h0D,
    parameter logic [7:0]  LINEFEED = 8'h0A
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_data_latch,
    input  logic [7:0]    i_data,
    output logic          o_line_valid,
    output logic [AW:0]   o_line_len,
    output logic          o_rd_valid,
    output logic [7:0]    o_rd_data,
    input  logic          i_rd_ready,
    output logic          o_overflow,
    output logic          o_drop
);

    // state   | meaning
    // COLLECT | storing bytes until the CR,LF terminator
    // DRAIN   | complete line held, streaming it to the consumer
    // DISCARD | over-long line, skipping bytes until the next terminator
    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DRAIN   = 2'd1,
        DISCARD = 2'd2
    } state_t;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    state_t      state_q,      state_d;
    logic [AW:0] count_q,      count_d;
    logic [AW:0] rd_ptr_q,     rd_ptr_d;
    logic        prev_cr_q,    prev_cr_d;
    logic        line_valid_q, line_valid_d;
    logic [AW:0] line_len_q,   line_len_d;
    logic        rd_valid_q,   rd_valid_d;
    logic [7:0]  rd_data_q,    rd_data_d;
    logic        overflow_q,   overflow_d;
    logic        drop_q,       drop_d;

    logic [7:0]  mem_q [DEPTH];
    logic        wr_en;
    logic        is_term;
    logic        finish;
    logic [AW:0] count_inc;

    assign is_term   = i_data_latch && prev_cr_q && (i_data == LINEFEED);
    assign count_inc = count_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        prev_cr_d    = prev_cr_q;
        line_valid_d = line_valid_q;
        line_len_d   = line_len_q;
        rd_valid_d   = rd_valid_q;
        rd_data_d    = rd_data_q;
        overflow_d   = 1'b0;
        drop_d       = 1'b0;
        wr_en        = 1'b0;
        finish       = 1'b0;

        case (state_q)
            COLLECT: begin
                if (i_data_latch) begin
                    wr_en     = 1'b1;
                    count_d   = count_inc;
                    prev_cr_d = (i_data == CARRIAGE);
                    if (is_term) begin
                        state_d      = DRAIN;
                        line_valid_d = 1'b1;
                        rd_ptr_d     = (AW+1)'(1);
                        // mem[0] is always written before a terminator can arrive
                        rd_data_d    = mem_q[0];
`ifdef LINE_BUF_STRIP_EN
                        line_len_d   = count_q - (AW+1)'(1);
                        rd_valid_d   = (line_len_d != '0);
`else
                        line_len_d   = count_inc;
                        rd_valid_d   = 1'b1;
`endif
                    end else if (count_inc == DEPTH_W) begin
                        state_d    = DISCARD;
                        overflow_d = 1'b1;
                        count_d    = '0;
                    end
                end
            end

            DRAIN: begin
                if (i_data_latch) begin
                    drop_d = 1'b1;
                end
`ifdef LINE_BUF_STRIP_EN
                if (!rd_valid_q) begin
                    finish = 1'b1;
                end else
`endif
                if (rd_valid_q && i_rd_ready) begin
                    if (rd_ptr_q == line_len_q) begin
                        finish = 1'b1;
                    end else begin
                        rd_data_d = mem_q[rd_ptr_q[AW-1:0]];
                        rd_ptr_d  = rd_ptr_q + 1'b1;
                    end
                end
                if (finish) begin
                    state_d      = COLLECT;
                    line_valid_d = 1'b0;
                    line_len_d   = '0;
                    rd_valid_d   = 1'b0;
                    count_d      = '0;
                    rd_ptr_d     = '0;
                    prev_cr_d    = 1'b0;
                end
            end

            DISCARD: begin
                if (i_data_latch) begin
                    prev_cr_d = (i_data == CARRIAGE);
                    if (is_term) begin
                        state_d = COLLECT;
                        count_d = '0;
                    end
                end
            end

            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= COLLECT;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            prev_cr_q    <= 1'b0;
            line_valid_q <= 1'b0;
            line_len_q   <= '0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            overflow_q   <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            prev_cr_q    <= prev_cr_d;
            line_valid_q <= line_valid_d;
            line_len_q   <= line_len_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            overflow_q   <= overflow_d;
            drop_q       <= drop_d;
        end
    end

    // Storage array carries no reset; only locations below count are ever read.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem_q[count_q[AW-1:0]] <= i_data;
        end
    end

    assign o_line_valid = line_valid_q;
    assign o_line_len   = line_len_q;
    assign o_rd_valid   = rd_valid_q;
    assign o_rd_data    = rd_data_q;
    assign o_overflow   = overflow_q;
    assign o_drop       = drop_q;

endmodule

// File: tb/tb_rx_line_buffer.sv
// Directed bench for rx_line_buffer: per-cycle vector table plus a reset-during-DRAIN sequence.
module tb_rx_line_buffer;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_data_latch = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic       i_rd_ready = 1'b0;
    logic       o_line_valid;
    logic [6:0] o_line_len;
    logic       o_rd_valid;
    logic [7:0] o_rd_data;
    logic       o_overflow;
    logic       o_drop;

    int checks = 0;
    int errors = 0;

    rx_line_buffer dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_data_latch (i_data_latch),
        .i_data       (i_data),
        .o_line_valid (o_line_valid),
        .o_line_len   (o_line_len),
        .o_rd_valid   (o_rd_valid),
        .o_rd_data    (o_rd_data),
        .i_rd_ready   (i_rd_ready),
        .o_overflow   (o_overflow),
        .o_drop       (o_drop)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic       latch;
        logic [7:0] data;
        logic       ready;
        logic       lv;
        logic [6:0] len;
        logic       rv;
        logic [7:0] rd;
        logic       ovf;
        logic       drop;
    } vec_t;

    vec_t vecs[$];

    task automatic push(input logic latch, input logic [7:0] data, input logic ready,
                        input logic lv, input int len, input logic rv, input logic [7:0] rd,
                        input logic ovf = 1'b0, input logic drop = 1'b0);
        vec_t v;
        v.latch = latch; v.data = data; v.ready = ready;
        v.lv = lv; v.len = 7'(len); v.rv = rv; v.rd = rd; v.ovf = ovf; v.drop = drop;
        vecs.push_back(v);
    endtask

    // byte during COLLECT/DISCARD where no output is expected to change
    task automatic push_quiet(input logic [7:0] b, input logic ready = 1'b1);
        push(1'b1, b, ready, 1'b0, 0, 1'b0, 8'h00);
    endtask

    task automatic check_vec(input string name, input vec_t v);
        logic bad;
        bad = (o_line_valid !== v.lv) || (o_rd_valid !== v.rv) ||
              (o_overflow !== v.ovf) || (o_drop !== v.drop) ||
              (v.lv && (o_line_len !== v.len)) || (v.rv && (o_rd_data !== v.rd));
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL %s: got lv=%0b len=%0d rv=%0b rd=%02h ovf=%0b drop=%0b, want lv=%0b len=%0d rv=%0b rd=%02h ovf=%0b drop=%0b",
                     name, o_line_valid, o_line_len, o_rd_valid, o_rd_data, o_overflow, o_drop,
                     v.lv, v.len, v.rv, v.rd, v.ovf, v.drop);
        end
    endtask

    task automatic apply_vec(input string name, input vec_t v);
        i_data_latch = v.latch;
        i_data       = v.data;
        i_rd_ready   = v.ready;
        @(negedge i_clk);
        check_vec(name, v);
    endtask

    task automatic check_zero(input string name);
        vec_t z;
        z.latch = 1'b0; z.data = 8'h00; z.ready = 1'b0;
        z.lv = 1'b0; z.len = 7'd0; z.rv = 1'b0; z.rd = 8'h00; z.ovf = 1'b0; z.drop = 1'b0;
        check_vec(name, z);
        checks++;
        if (o_line_len !== 7'd0 || o_rd_data !== 8'h00) begin
            errors++;
            $display("FAIL %s_data: got len=%0d rd=%02h, want len=0 rd=00", name, o_line_len, o_rd_data);
        end
    endtask

    initial begin
        vec_t v;

`ifdef LINE_BUF_STRIP_EN
        // "HI\r\n": terminator stripped
        push_quiet(8'h48); push_quiet(8'h49); push_quiet(8'h0D);
        push(1, 8'h0A, 1, 1, 2, 1, 8'h48);
        push(0, 8'h00, 1, 1, 2, 1, 8'h49);
        push(0, 8'h00, 1, 0, 0, 0, 8'h00);
        // "\r\n": zero-length line for one cycle, no data
        push_quiet(8'h0D);
        push(1, 8'h0A, 1, 1, 0, 0, 8'h00);
        push(0, 8'h00, 1, 0, 0, 0, 8'h00);
        push(0, 8'h00, 1, 0, 0, 0, 8'h00);
        // "A\rB\r\n": CR followed by non-LF stays as data
        push_quiet(8'h41); push_quiet(8'h0D); push_quiet(8'h42); push_quiet(8'h0D);
        push(1, 8'h0A, 1, 1, 3, 1, 8'h41);
        push(0, 8'h00, 1, 1, 3, 1, 8'h0D);
        push(0, 8'h00, 1, 1, 3, 1, 8'h42);
        push(0, 8'h00, 1, 0, 0, 0, 8'h00);
`else
        // basic line, ready held high
        push_quiet(8'h48); push_quiet(8'h49); push_quiet(8'h0D);
        push(1, 8'h0A, 1, 1, 4, 1, 8'h48);
        push(0, 8'h00, 1, 1, 4, 1, 8'h49);
        push(0, 8'h00, 1, 1, 4, 1, 8'h0D);
        push(0, 8'h00, 1, 1, 4, 1, 8'h0A);
        push(0, 8'h00, 1, 0, 0, 0, 8'h00);
        // backpressure: data held while ready low
        push_quiet(8'h48, 0); push_quiet(8'h49, 0); push_quiet(8'h0D, 0);
        push(1, 8'h0A, 0, 1, 4, 1, 8'h48);
        for (int i = 0; i < 5; i++) push(0, 8'h00, 0, 1, 4, 1, 8'h48);
        push(0, 8'h00, 1, 1, 4, 1, 8'h49);
        push(0, 8'h00, 1, 1, 4, 1, 8'h0D);
        push(0, 8'h00, 1, 1, 4, 1, 8'h0A);
        push(0, 8'h00, 1, 0, 0, 0, 8'h00);
        // byte during DRAIN is dropped
        push_quiet(8'h5A); push_quiet(8'h0D);
        push(1, 8'h0A, 0, 1, 3, 1, 8'h5A);
        push(1, 8'h55, 0, 1, 3, 1, 8'h5A, 0, 1);
        push(0, 8'h00, 0, 1, 3, 1, 8'h5A, 0, 0);
        push(0, 8'h00, 1, 1, 3, 1, 8'h0D);
        push(0, 8'h00, 1, 1, 3, 1, 8'h0A);
        push(0, 8'h00, 1, 0, 0, 0, 8'h00);
        push_quiet(8'h51); push_quiet(8'h0D);
        push(1, 8'h0A, 1, 1, 3, 1, 8'h51);
        push(0, 8'h00, 1, 1, 3, 1, 8'h0D);
        push(0, 8'h00, 1, 1, 3, 1, 8'h0A);
        push(0, 8'h00, 1, 0, 0, 0, 8'h00);
        // lone LF and CR+non-LF are data; CR CR LF terminates
        push_quiet(8'h41); push_quiet(8'h0A); push_quiet(8'h42); push_quiet(8'h0D);
        push_quiet(8'h43); push_quiet(8'h0D); push_quiet(8'h0D);
        push(1, 8'h0A, 1, 1, 8, 1, 8'h41);
        push(0, 8'h00, 1, 1, 8, 1, 8'h0A);
        push(0, 8'h00, 1, 1, 8, 1, 8'h42);
        push(0, 8'h00, 1, 1, 8, 1, 8'h0D);
        push(0, 8'h00, 1, 1, 8, 1, 8'h43);
        push(0, 8'h00, 1, 1, 8, 1, 8'h0D);
        push(0, 8'h00, 1, 1, 8, 1, 8'h0D);
        push(0, 8'h00, 1, 1, 8, 1, 8'h0A);
        push(0, 8'h00, 1, 0, 0, 0, 8'h00);
        // 64 bytes without terminator: overflow, then discard until "\r\n"
        for (int i = 0; i < 63; i++) push_quiet(8'h41);
        push(1, 8'h41, 1, 0, 0, 0, 8'h00, 1, 0);
        push_quiet(8'h58); push_quiet(8'h0D); push_quiet(8'h0A);
        push(0, 8'h00, 1, 0, 0, 0, 8'h00);
        push(0, 8'h00, 1, 0, 0, 0, 8'h00);
        push_quiet(8'h4F); push_quiet(8'h4B); push_quiet(8'h0D);
        push(1, 8'h0A, 1, 1, 4, 1, 8'h4F);
        push(0, 8'h00, 1, 1, 4, 1, 8'h4B);
        push(0, 8'h00, 1, 1, 4, 1, 8'h0D);
        push(0, 8'h00, 1, 1, 4, 1, 8'h0A);
        push(0, 8'h00, 1, 0, 0, 0, 8'h00);
        // terminator exactly on byte 64: valid full-depth line, no overflow
        for (int i = 0; i < 62; i++) push_quiet(8'h41);
        push_quiet(8'h0D);
        push(1, 8'h0A, 1, 1, 64, 1, 8'h41);
        for (int i = 0; i < 61; i++) push(0, 8'h00, 1, 1, 64, 1, 8'h41);
        push(0, 8'h00, 1, 1, 64, 1, 8'h0D);
        push(0, 8'h00, 1, 1, 64, 1, 8'h0A);
        push(0, 8'h00, 1, 0, 0, 0, 8'h00);
`endif

        i_rst = 1'b1;
        @(negedge i_clk);
        check_zero("reset_state");
        i_rst = 1'b0;

        foreach (vecs[i]) begin
            apply_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // reset asserted while a line is held
        apply_vec("rst_seq_b0", '{1, 8'h48, 0, 0, 7'd0, 0, 8'h00, 0, 0});
        apply_vec("rst_seq_b1", '{1, 8'h49, 0, 0, 7'd0, 0, 8'h00, 0, 0});
        apply_vec("rst_seq_b2", '{1, 8'h0D, 0, 0, 7'd0, 0, 8'h00, 0, 0});
`ifdef LINE_BUF_STRIP_EN
        apply_vec("rst_seq_line", '{1, 8'h0A, 0, 1, 7'd2, 1, 8'h48, 0, 0});
`else
        apply_vec("rst_seq_line", '{1, 8'h0A, 0, 1, 7'd4, 1, 8'h48, 0, 0});
`endif
        i_data_latch = 1'b0;
        i_rst = 1'b1;
        #1;
        check_zero("rst_async");
        @(negedge i_clk);
        check_zero("rst_held");
        i_rst = 1'b0;
        @(negedge i_clk);
        check_zero("rst_release");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
